// File: rtl/dfdd_pkg.sv
// rtl/dfdd_pkg.sv - shared widths, pixel record and floating-point helpers for the depth output path
package dfdd_pkg;

    localparam int DFDD_IMG_WIDTH  = 640;
    localparam int DFDD_IMG_HEIGHT = 480;
    localparam int DFDD_EXP_WIDTH  = 8;
    localparam int DFDD_FRAC_WIDTH = 23;
    localparam int FP_MAX_WIDTH    = 64;

    function automatic int fp_width(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    localparam int DFDD_FP_WIDTH = fp_width(DFDD_EXP_WIDTH, DFDD_FRAC_WIDTH);

    typedef struct packed {
        logic [DFDD_FP_WIDTH-1:0] z;
        logic [DFDD_FP_WIDTH-1:0] c;
        logic [15:0]              col;
        logic [15:0]              row;
        logic                     conf;
        logic                     sof;
        logic                     eof;
    } pixel_out_t;

    // Operands arrive zero-extended into a 64-bit container so one helper serves any FP format.
    function automatic logic is_nan(input logic [FP_MAX_WIDTH-1:0] v, input int exp_w, input int frac_w);
        logic [FP_MAX_WIDTH-1:0] exp_mask;
        logic [FP_MAX_WIDTH-1:0] frac_mask;
        frac_mask = (64'd1 << frac_w) - 64'd1;
        exp_mask  = ((64'd1 << exp_w) - 64'd1) << frac_w;
        return ((v & exp_mask) == exp_mask) && ((v & frac_mask) != '0);
    endfunction

    function automatic logic fp_mag_ge(input logic [FP_MAX_WIDTH-1:0] a,
                                       input logic [FP_MAX_WIDTH-1:0] b,
                                       input int fp_w);
        logic [FP_MAX_WIDTH-1:0] mag_mask;
        mag_mask = (64'd1 << (fp_w - 1)) - 64'd1;
        return (a & mag_mask) >= (b & mag_mask);
    endfunction

endpackage

// File: rtl/dfdd_stream_fifo.sv
// rtl/dfdd_stream_fifo.sv - show-ahead synchronous FIFO with full/empty flags
module dfdd_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_rd   = rd_i && !empty_o;
    assign do_wr   = wr_i && (!full_o || do_rd);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/z_c_output_stage.sv
// rtl/z_c_output_stage.sv - confidence mask, raster check and show-ahead output FIFO
// DFDD_CONF_MASK_EN enables confidence thresholding and depth masking.
module z_c_output_stage
    import dfdd_pkg::*;
#(
    parameter int EXP_WIDTH    = DFDD_EXP_WIDTH,
    parameter int FRAC_WIDTH   = DFDD_FRAC_WIDTH,
    parameter int IMG_WIDTH    = DFDD_IMG_WIDTH,
    parameter int IMG_HEIGHT   = DFDD_IMG_HEIGHT,
    parameter int FIFO_DEPTH   = 8,
    parameter int FP_WIDTH_REG = fp_width(EXP_WIDTH, FRAC_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] z_i,
    input  logic [FP_WIDTH_REG-1:0] c_i,
    input  logic [15:0]             col_i,
    input  logic [15:0]             row_i,
    input  logic                    valid_i,
    input  logic [FP_WIDTH_REG-1:0] thresh_i,
    input  logic                    clear_i,
    output logic [FP_WIDTH_REG-1:0] z_o,
    output logic [FP_WIDTH_REG-1:0] c_o,
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    conf_o,
    output logic                    sof_o,
    output logic                    eof_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    overflow_o,
    output logic                    frame_err_o,
    output logic [15:0]             frame_count_o
);
    typedef struct packed {
        logic [FP_WIDTH_REG-1:0] z;
        logic [FP_WIDTH_REG-1:0] c;
        logic [15:0]             col;
        logic [15:0]             row;
        logic                    conf;
        logic                    sof;
        logic                    eof;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic                    conf;
    logic [FP_WIDTH_REG-1:0] z_sel;

`ifdef DFDD_CONF_MASK_EN
    logic [FP_MAX_WIDTH-1:0] c_ext, t_ext;
    assign c_ext = FP_MAX_WIDTH'(c_i);
    assign t_ext = FP_MAX_WIDTH'(thresh_i);
    assign conf  = !c_i[FP_WIDTH_REG-1] && !is_nan(c_ext, EXP_WIDTH, FRAC_WIDTH)
                   && fp_mag_ge(c_ext, t_ext, FP_WIDTH_REG);
    assign z_sel = conf ? z_i : '0;
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh_i;
    assign conf  = 1'b1;
    assign z_sel = z_i;
`endif

    logic        sof, eof, pos_err;
    logic [15:0] exp_col_q, exp_col_d, exp_row_q, exp_row_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        overflow_q, overflow_d, frame_err_q, frame_err_d;
    logic        s1_valid_q;
    entry_t      s1_q, s1_d;

    assign sof     = (col_i == '0) && (row_i == '0);
    assign eof     = (col_i == 16'(IMG_WIDTH - 1)) && (row_i == 16'(IMG_HEIGHT - 1));
    assign pos_err = valid_i && ((col_i != exp_col_q) || (row_i != exp_row_q));
    assign s1_d    = '{z: z_sel, c: c_i, col: col_i, row: row_i, conf: conf, sof: sof, eof: eof};

    // Expected position always resyncs to the pixel just seen, so one skip raises one error.
    always_comb begin
        exp_col_d     = exp_col_q;
        exp_row_d     = exp_row_q;
        frame_count_d = frame_count_q;
        if (valid_i) begin
            if (eof) begin
                exp_col_d     = '0;
                exp_row_d     = '0;
                frame_count_d = frame_count_q + 16'd1;
            end else if (col_i == 16'(IMG_WIDTH - 1)) begin
                exp_col_d = '0;
                exp_row_d = row_i + 16'd1;
            end else begin
                exp_col_d = col_i + 16'd1;
                exp_row_d = row_i;
            end
        end
    end

    logic   fifo_full, fifo_empty, fifo_rd, fifo_wr, drop;
    entry_t fifo_rdata, head;

    assign fifo_rd     = !fifo_empty && ready_i;
    assign fifo_wr     = s1_valid_q && (!fifo_full || fifo_rd);
    assign drop        = s1_valid_q && fifo_full && !fifo_rd;
    assign overflow_d  = drop || (overflow_q && !clear_i);
    assign frame_err_d = pos_err || (frame_err_q && !clear_i);

    dfdd_stream_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_i    (fifo_wr),
        .wdata_i (s1_q),
        .rd_i    (fifo_rd),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid_q    <= 1'b0;
            s1_q          <= '0;
            exp_col_q     <= '0;
            exp_row_q     <= '0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            s1_valid_q    <= valid_i;
            if (valid_i) begin
                s1_q <= s1_d;
            end
            exp_col_q     <= exp_col_d;
            exp_row_q     <= exp_row_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Data outputs read as zero while nothing is queued.
    assign head          = fifo_empty ? '0 : fifo_rdata;
    assign valid_o       = !fifo_empty;
    assign z_o           = head.z;
    assign c_o           = head.c;
    assign col_o         = head.col;
    assign row_o         = head.row;
    assign conf_o        = head.conf;
    assign sof_o         = head.sof;
    assign eof_o         = head.eof;
    assign overflow_o    = overflow_q;
    assign frame_err_o   = frame_err_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_z_c_output_stage.sv
// tb/tb_z_c_output_stage.sv - randomized and directed bench against a queue-level reference model
module tb_z_c_output_stage;
    localparam int EW = 8, FW = 23, IW = 4, IH = 2, DEPTH = 4;
`ifdef DFDD_CONF_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] z_i = '0, c_i = '0, thresh_i = 32'h3F00_0000;
    logic [15:0] col_i = '0, row_i = '0;
    logic        valid_i = 1'b0, clear_i = 1'b0, ready_i = 1'b1;
    logic [31:0] z_o, c_o;
    logic [15:0] col_o, row_o, frame_count_o;
    logic        conf_o, sof_o, eof_o, valid_o, overflow_o, frame_err_o;

    z_c_output_stage #(
        .EXP_WIDTH(EW), .FRAC_WIDTH(FW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .z_i(z_i), .c_i(c_i), .col_i(col_i), .row_i(row_i),
        .valid_i(valid_i), .thresh_i(thresh_i), .clear_i(clear_i), .z_o(z_o), .c_o(c_o),
        .col_o(col_o), .row_o(row_o), .conf_o(conf_o), .sof_o(sof_o), .eof_o(eof_o),
        .valid_o(valid_o), .ready_i(ready_i), .overflow_o(overflow_o),
        .frame_err_o(frame_err_o), .frame_count_o(frame_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] z;
        logic [31:0] c;
        logic [15:0] col;
        logic [15:0] row;
        logic        conf;
        logic        sof;
        logic        eof;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_s1;
    logic        m_s1_v, m_ovf, m_ferr;
    logic [15:0] m_fc;
    int          m_next;
    int          pc, pr;

    function automatic logic model_conf(input logic [31:0] c, input logic [31:0] t);
        logic nan;
        nan = (c[30:23] == 8'hFF) && (c[22:0] != 23'd0);
        return MASK_EN ? (!c[31] && !nan && (c[30:0] >= t[30:0])) : 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_s1 = '0; m_s1_v = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0; m_fc = '0; m_next = 0;
    endtask

    task automatic model_edge();
        ent_t e;
        logic ovf_set, ferr_set;
        int   lin;
        if (!rst_i) begin
            model_reset();
            return;
        end
        ovf_set = 1'b0; ferr_set = 1'b0;
        if (mq.size() != 0 && ready_i) void'(mq.pop_front());
        if (m_s1_v) begin
            if (mq.size() < DEPTH) mq.push_back(m_s1);
            else ovf_set = 1'b1;
        end
        m_s1_v = valid_i;
        if (valid_i) begin
            lin    = int'(row_i) * IW + int'(col_i);
            e.conf = model_conf(c_i, thresh_i);
            e.z    = e.conf ? z_i : 32'h0;
            e.c    = c_i;
            e.col  = col_i;
            e.row  = row_i;
            e.sof  = (lin == 0);
            e.eof  = (lin == IW * IH - 1);
            if (lin != m_next) ferr_set = 1'b1;
            m_next = (lin + 1) % (IW * IH);
            if (e.eof) m_fc++;
            m_s1 = e;
        end
        if (clear_i) begin m_ovf = 1'b0; m_ferr = 1'b0; end
        if (ovf_set)  m_ovf  = 1'b1;
        if (ferr_set) m_ferr = 1'b1;
    endtask

    task automatic check_outputs();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        check_val("valid_o", 64'(valid_o), 64'(mq.size() != 0));
        check_val("z_o", 64'(z_o), 64'(h.z));
        check_val("c_o", 64'(c_o), 64'(h.c));
        check_val("col_row", 64'({col_o, row_o}), 64'({h.col, h.row}));
        check_val("conf_sof_eof", 64'({conf_o, sof_o, eof_o}), 64'({h.conf, h.sof, h.eof}));
        check_val("overflow_o", 64'(overflow_o), 64'(m_ovf));
        check_val("frame_err_o", 64'(frame_err_o), 64'(m_ferr));
        check_val("frame_count_o", 64'(frame_count_o), 64'(m_fc));
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic idle();
        valid_i = 1'b0;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] z, input logic [31:0] c);
        col_i = 16'(pc); row_i = 16'(pr); z_i = z; c_i = c; valid_i = 1'b1;
        tick();
        valid_i = 1'b0; clear_i = 1'b0;
        if (pc == IW - 1) begin pc = 0; pr = (pr + 1) % IH; end
        else pc++;
    endtask

    task automatic send_at(input int col, input int row);
        pc = col; pr = row;
        send($urandom, 32'h3F40_0000);
    endtask

    task automatic do_reset();
        rst_i = 1'b0; valid_i = 1'b0; clear_i = 1'b0;
        #1;
        check_val("rst_valid_o", 64'(valid_o), 64'd0);
        check_val("rst_overflow_o", 64'(overflow_o), 64'd0);
        check_val("rst_frame_err_o", 64'(frame_err_o), 64'd0);
        check_val("rst_frame_count_o", 64'(frame_count_o), 64'd0);
        check_val("rst_z_conf", 64'({z_o, conf_o}), 64'd0);
        model_reset();
        pc = 0; pr = 0;
        tick();
        rst_i = 1'b1;
    endtask

    int          n_sof, n_eof, k, n;
    logic [31:0] sof_pos, eof_pos;
    logic [31:0] mask_c [5] = '{32'h3F40_0000, 32'h3E80_0000, 32'h7FC0_0000, 32'hBF40_0000, 32'h3F00_0000};
    logic        mask_e [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic scan();
        if (valid_o && ready_i) begin
            if (sof_o) begin n_sof++; sof_pos = {col_o, row_o}; end
            if (eof_o) begin n_eof++; eof_pos = {col_o, row_o}; end
        end
    endtask

    task automatic mask_scan();
        logic e;
        if (valid_o && ready_i && k < 5) begin
            e = MASK_EN ? mask_e[k] : 1'b1;
            check_val("mask_conf", 64'(conf_o), 64'(e));
            check_val("mask_z", 64'(z_o), e ? 64'h4040_0000 : 64'd0);
            k++;
        end
    endtask

    function automatic logic [31:0] rand_c();
        case ($urandom_range(0, 6))
            0: return thresh_i;
            1: return thresh_i + 32'd1;
            2: return thresh_i - 32'd1;
            3: return {1'b0, 8'hFF, 23'($urandom_range(1, 23'h7F_FFFF))};
            4: return 32'h7F80_0000;
            5: return {1'b1, 31'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        model_reset();
        @(negedge clk_i);
        do_reset();

        // confidence mask and FP edge values
        ready_i = 1'b1; k = 0;
        for (int i = 0; i < 5; i++) begin
            send(32'h4040_0000, mask_c[i]);
            mask_scan();
        end
        for (int i = 0; i < 4; i++) begin idle(); mask_scan(); end
        check_val("mask_count", 64'(k), 64'd5);

        // full in-order frame, latency
        do_reset();
        n_sof = 0; n_eof = 0; sof_pos = '1; eof_pos = '1;
        for (int i = 0; i < IW * IH; i++) begin
            send($urandom, 32'h3F40_0000);
            if (i == 0) check_val("lat_n1", 64'(valid_o), 64'd0);
            if (i == 1) check_val("lat_n2", 64'(valid_o), 64'd1);
            scan();
        end
        for (int i = 0; i < 3; i++) begin idle(); scan(); end
        check_val("n_sof", 64'(n_sof), 64'd1);
        check_val("sof_pos", 64'(sof_pos), 64'h0000_0000);
        check_val("n_eof", 64'(n_eof), 64'd1);
        check_val("eof_pos", 64'(eof_pos), 64'h0003_0001);
        check_val("frame_count_1", 64'(frame_count_o), 64'd1);
        check_val("frame_err_0", 64'(frame_err_o), 64'd0);

        // overflow with stalled consumer
        do_reset();
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send($urandom, 32'h3F40_0000);
        idle(); idle();
        check_val("ovf_set", 64'(overflow_o), 64'd1);
        ready_i = 1'b1; n = 0;
        for (int g = 0; g < 12 && valid_o; g++) begin
            check_val("ovf_drain_pos", 64'({col_o, row_o}), 64'({16'(n), 16'd0}));
            n++;
            idle();
        end
        check_val("ovf_drain_n", 64'(n), 64'(DEPTH));
        clear_i = 1'b1; idle();
        check_val("ovf_clear", 64'(overflow_o), 64'd0);

        // raster order errors and clear priority
        do_reset();
        send_at(0, 0); send_at(2, 0);
        check_val("ord_err", 64'(frame_err_o), 64'd1);
        clear_i = 1'b1; send_at(3, 0);
        check_val("ord_resync_clear", 64'(frame_err_o), 64'd0);
        clear_i = 1'b1; send_at(2, 1);
        check_val("ord_set_wins", 64'(frame_err_o), 64'd1);
        clear_i = 1'b1; idle();
        check_val("ord_clear", 64'(frame_err_o), 64'd0);

        // reset with entries queued
        do_reset();
        for (int i = 0; i < IW * IH; i++) send($urandom, rand_c());
        idle(); idle(); idle();
        ready_i = 1'b0;
        send_at(0, 0); send_at(1, 0); send_at(3, 0);
        idle(); idle();
        check_val("mid_valid", 64'(valid_o), 64'd1);
        check_val("mid_ferr", 64'(frame_err_o), 64'd1);
        check_val("mid_fc", 64'(frame_count_o), 64'd1);
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < IW * IH; i++) send($urandom, rand_c());
        idle(); idle(); idle();
        check_val("post_rst_ferr", 64'(frame_err_o), 64'd0);
        check_val("post_rst_fc", 64'(frame_count_o), 64'd1);

        // randomized traffic, two threshold settings
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            thresh_i = (ph == 0) ? 32'h3F00_0000 : {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            for (int i = 0; i < 2500; i++) begin
                if ((i % 600) < 300) ready_i = ($urandom_range(0, 3) != 0);
                else                 ready_i = ($urandom_range(0, 3) == 0);
                clear_i = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 9) < 7) begin
                    if ($urandom_range(0, 19) == 0) begin
                        pc = $urandom_range(0, IW - 1);
                        pr = $urandom_range(0, IH - 1);
                    end
                    send($urandom, rand_c());
                end else begin
                    idle();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/z_c_output_stage.md
Name: z_c_output_stage

Overview:
- Sits directly downstream of the single-scale V/W divider. Consumes its per-pixel stream: depth z, confidence c, col, row, valid.
- Thresholds confidence, masks low-confidence depth and tags start/end of frame.
- Checks raster order and buffers results in a small FIFO, so a backpressured consumer can drain via valid/ready. The divider has no ready, so overflow is detected and flagged, never stalled.

Parameters:
- EXP_WIDTH, 8, FP exponent width
- FRAC_WIDTH, 23, FP fraction width
- IMG_WIDTH, 640, pixels per row
- IMG_HEIGHT, 480, rows per frame
- FIFO_DEPTH, 8, output FIFO entries (power of two, >=2)
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, local width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- z_i  in  FP_WIDTH_REG  depth from divider
- c_i  in  FP_WIDTH_REG  confidence from divider
- col_i  in  16  pixel column
- row_i  in  16  pixel row
- valid_i  in  1  input pixel strobe (no backpressure)
- thresh_i  in  FP_WIDTH_REG  confidence threshold; quasi-static
- clear_i  in  1  one-cycle pulse clearing sticky flags
- z_o  out  FP_WIDTH_REG  masked depth
- c_o  out  FP_WIDTH_REG  confidence, passed through
- col_o  out  16  column
- row_o  out  16  row
- conf_o  out  1  1 = pixel passed threshold
- sof_o  out  1  first pixel of frame
- eof_o  out  1  last pixel of frame
- valid_o  out  1  output data valid
- ready_i  in  1  consumer ready
- overflow_o  out  1  sticky: a pixel was dropped
- frame_err_o  out  1  sticky: raster order violation
- frame_count_o  out  16  completed frames, wraps

Behaviour:
- Reset (rst_i low, async): all outputs 0, FIFO empty, expected position (0,0), frame_count 0.
- Stage 1 (registered, 1 cycle), for each valid_i:
  - Compute conf = (c sign bit 0) AND (c not NaN) AND (c[FP_WIDTH_REG-2:0] >= thresh_i[FP_WIDTH_REG-2:0], unsigned).
  - NaN = exponent all ones and fraction nonzero.
  - z_stage = conf ? z_i : all-zero.
  - sof = (col==0 && row==0); eof = (col==IMG_WIDTH-1 && row==IMG_HEIGHT-1).
- Order check, on each valid_i:
  - If (col_i,row_i) differs from the expected position, set frame_err sticky.
  - Then, in all cases, set expected position to the successor of (col_i,row_i): col+1, wrapping to 0 with row+1; after eof it wraps to (0,0).
  - frame_count increments on each accepted eof pixel, independent of FIFO acceptance.
- FIFO write: stage-1 entry written the cycle after valid_i.
- FIFO full, no read that cycle: entry dropped, overflow sticky set.
- FIFO full with simultaneous read: write accepted, nothing dropped.
- Output is show-ahead:
  - valid_o = FIFO non-empty; outputs show the head entry.
  - Pop on valid_o && ready_i.
  - Outputs hold stable while valid_o && !ready_i.
- Latency: valid_i at cycle N, FIFO empty → valid_o high at N+2.
- Throughput: 1 pixel/cycle when ready_i is held high.
- clear_i: clears overflow and frame_err the following cycle. A set event in the same cycle wins; the flag stays 1.
- Reset mid-stream: in-flight stage-1 and FIFO contents are discarded.

Optional Feature:
- DFDD_CONF_MASK_EN defined: thresholding and z masking as above.
- Undefined:
  - conf_o = 1 whenever valid_o.
  - z_o = z_i unmodified.
  - thresh_i is ignored; no comparator is synthesized.
  - Latency is unchanged.

Decomposition:
- Package dfdd_pkg:
  - FP width localparam function.
  - Packed struct pixel_out_t {z, c, col, row, conf, sof, eof}.
  - Default IMG_WIDTH/IMG_HEIGHT constants.
  - is_nan / fp_mag_ge helper functions.
- One sub-module dfdd_stream_fifo:
  - Parameterised width and depth; show-ahead read.
  - Ports: full, empty, write, read.
  - Asynchronous active-low reset.

Test Plan (fp32, thresh_i=0x3F000000 = 0.5):
- Mask: c=0x3F400000, z=0x40400000 → z_o=0x40400000, conf_o=1; c=0x3E800000 → z_o=0, conf_o=0.
- Edge values: c=0x7FC00000 (NaN) → conf_o=0; c=0xBF400000 (negative) → conf_o=0; c=thresh exactly → conf_o=1.
- Frame, IMG 4x2: 8 in-order pixels, ready_i=1:
  - sof_o on (0,0), eof_o on (3,1).
  - frame_count_o=1, frame_err_o=0.
  - valid_o two cycles after each valid_i.
- Overflow, FIFO_DEPTH=4, ready_i=0: 5 pixels → overflow_o=1. Then ready_i=1 → exactly pixels 0..3 emerge in order.
- Order error: send (0,0),(2,0) → frame_err_o=1. Next (3,0) gives no new error. clear_i → 0.
- Reset mid-stream: rst_i low with 3 entries queued → valid_o=0 and flags/count 0 immediately (async). Next frame starting at (0,0) → no frame_err.
